// File: rtl/ula_unit_pkg.sv
// rtl/ula_unit_pkg.sv - shared REDUX-V datapath widths and opcode constants
package ula_unit_pkg;

  localparam int BITS = 8;
  localparam int OP   = 8;

  // Decoder and assembler tooling use these encodings as well.
  localparam logic [OP-1:0] OP_NOT = 8'd0;
  localparam logic [OP-1:0] OP_AND = 8'd1;
  localparam logic [OP-1:0] OP_OR  = 8'd2;
  localparam logic [OP-1:0] OP_XOR = 8'd3;
  localparam logic [OP-1:0] OP_ADD = 8'd4;
  localparam logic [OP-1:0] OP_SUB = 8'd5;
  localparam logic [OP-1:0] OP_SHL = 8'd6;
  localparam logic [OP-1:0] OP_SHR = 8'd7;

endpackage

// File: rtl/ula_unit_if.sv
// rtl/ula_unit_if.sv - operand/opcode/result bundle between register file and ALU
interface ula_unit_if #(
  parameter int BITS = ula_unit_pkg::BITS,
  parameter int OP   = ula_unit_pkg::OP
);

  logic [BITS-1:0] a_in;
  logic [BITS-1:0] b_in;
  logic [OP-1:0]   op_in;
  logic [BITS-1:0] result_out;

  modport master (
    output a_in,
    output b_in,
    output op_in,
    input  result_out
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  op_in,
    output result_out
  );

endinterface

// File: rtl/ula_unit_datapath.sv
// rtl/ula_unit_datapath.sv - combinational opcode mux producing the next ALU result
module ula_datapath
  import ula_unit_pkg::*;
#(
  parameter int BITS = ula_unit_pkg::BITS,
  parameter int OP   = ula_unit_pkg::OP
) (
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  input  logic [OP-1:0]   op_in,
  output logic [BITS-1:0] result
);

  logic shift_sat;

  // The whole of b_in is the shift amount; anything that pushes every bit out saturates to 0.
  assign shift_sat = (32'(b_in) >= BITS);

  always_comb begin
    result = '0;
    case (op_in)
      OP_NOT: result = ~b_in;
      OP_AND: result = a_in & b_in;
      OP_OR:  result = a_in | b_in;
      OP_XOR: result = a_in ^ b_in;
      OP_ADD: result = a_in + b_in;
      OP_SUB: result = a_in - b_in;
      OP_SHL: result = shift_sat ? '0 : (a_in << b_in);
      OP_SHR: result = shift_sat ? '0 : (a_in >> b_in);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ula_unit.sv
// rtl/ula_unit.sv - registered 8-function ALU, one-cycle latency, sync active-high reset
module ula_unit
  import ula_unit_pkg::*;
#(
  parameter int BITS = ula_unit_pkg::BITS,
  parameter int OP   = ula_unit_pkg::OP
) (
  input  logic        clk,
  input  logic        rst,
  ula_unit_if.slave   bus
);

  logic [BITS-1:0] dp_result;
  logic [BITS-1:0] result_d;
  logic [BITS-1:0] result_q;

  ula_datapath #(
    .BITS (BITS),
    .OP   (OP)
  ) u_datapath (
    .a_in   (bus.a_in),
    .b_in   (bus.b_in),
    .op_in  (bus.op_in),
    .result (dp_result)
  );

  always_comb begin
    result_d = dp_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.result_out = result_q;

endmodule

// File: tb/tb_ula_unit.sv
// tb/tb_ula_unit.sv - scoreboard bench for ula_unit
module tb_ula_unit;
  import ula_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  ula_unit_if u_if ();

  ula_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(logic [7:0] op, logic [7:0] a, logic [7:0] b);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    case (op)
      8'd0: return ~b;
      8'd1: return a & b;
      8'd2: return a | b;
      8'd3: return a ^ b;
      8'd4: return 8'((ai + bi) % 256);
      8'd5: return 8'((ai - bi + 256) % 256);
      8'd6: return (bi >= 8) ? 8'd0 : 8'((ai * (1 << bi)) % 256);
      8'd7: return (bi >= 8) ? 8'd0 : 8'(ai / (1 << bi));
      default: return 8'd0;
    endcase
  endfunction

  task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic r);
    u_if.op_in = op;
    u_if.a_in  = a;
    u_if.b_in  = b;
    rst        = r;
    exp_q.push_back(r ? 8'd0 : model(op, a, b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    logic       rv[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(OP_ADD, 8'd3, 8'd4, rv[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (u_if.result_out !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got %02h want %02h", i, u_if.result_out, exp);
      end
    end
  endtask

  task automatic test_logic();
    logic [7:0] exp;
    logic [7:0] vo[4] = '{OP_NOT, OP_AND, OP_OR, OP_XOR};
    logic [7:0] va[4] = '{8'hxx, 8'hFF, 8'h00, 8'h09};
    logic [7:0] vb[4] = '{8'h55, 8'hFF, 8'h00, 8'h01};
    logic [7:0] ve[4] = '{8'hAA, 8'hFF, 8'h00, 8'h08};
    for (int i = 0; i < 4; i++) begin
      drive(vo[i], va[i], vb[i], 1'b0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (u_if.result_out !== exp || exp !== ve[i]) begin
        errors++;
        $display("FAIL logic[%0d]: got %02h want %02h", i, u_if.result_out, ve[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [7:0] exp;
    logic [7:0] vo[5] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
    logic [7:0] va[5] = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd253};
    logic [7:0] vb[5] = '{8'd255, 8'd1, 8'd1, 8'd254, 8'd255};
    logic [7:0] ve[5] = '{8'd254, 8'd0, 8'd255, 8'd1, 8'd254};
    for (int i = 0; i < 5; i++) begin
      drive(vo[i], va[i], vb[i], 1'b0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (u_if.result_out !== exp || exp !== ve[i]) begin
        errors++;
        $display("FAIL arith[%0d]: got %02h want %02h", i, u_if.result_out, ve[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] exp;
    logic [7:0] vo[9] = '{OP_SHL, OP_SHR, OP_SHL, OP_SHR, OP_SHL, OP_SHR, OP_SHL, OP_SHR, OP_SHL};
    logic [7:0] va[9] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hFF, 8'h80, 8'h81};
    logic [7:0] vb[9] = '{8'd2, 8'd2, 8'd0, 8'd0, 8'd255, 8'd255, 8'd8, 8'd7, 8'd7};
    logic [7:0] ve[9] = '{8'hFC, 8'h3F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80};
    for (int i = 0; i < 9; i++) begin
      drive(vo[i], va[i], vb[i], 1'b0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (u_if.result_out !== exp || exp !== ve[i]) begin
        errors++;
        $display("FAIL shift[%0d]: got %02h want %02h", i, u_if.result_out, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic [7:0] op;
    for (int i = 0; i < 40; i++) begin
      op = (i < 8) ? 8'(i) : 8'($urandom_range(0, 9));
      drive(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 11) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 9)), 1'b0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (u_if.result_out !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d: got %02h want %02h", i, op, u_if.result_out, exp);
      end
    end
  endtask

  task automatic test_reserved_and_midreset();
    logic [7:0] exp;
    logic [7:0] vo[6] = '{8'd8, 8'd255, OP_ADD, OP_ADD, OP_SUB, OP_XOR};
    logic [7:0] va[6] = '{8'hFF, 8'h12, 8'd1, 8'd5, 8'd9, 8'hF0};
    logic [7:0] vb[6] = '{8'hFF, 8'h34, 8'd1, 8'd5, 8'd2, 8'h0F};
    logic       vr[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] ve[6] = '{8'h00, 8'h00, 8'd2, 8'd0, 8'd7, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      drive(vo[i], va[i], vb[i], vr[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (u_if.result_out !== exp || exp !== ve[i]) begin
        errors++;
        $display("FAIL resv_rst[%0d]: got %02h want %02h", i, u_if.result_out, ve[i]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    u_if.op_in = '0;
    u_if.a_in  = '0;
    u_if.b_in  = '0;
    rst        = 1'b1;
    tick();
    test_reset();
    test_logic();
    test_arith();
    test_shift();
    test_back_to_back();
    test_reserved_and_midreset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
